// File: rtl/mem_burst_master_if.sv
// rtl/mem_burst_master_if.sv - command and memory bus bundle for mem_burst_master
interface mem_burst_master_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 4
);
    logic                     iStart;
    logic                     iOp;
    logic [ADDRESS_WIDTH-1:0] iBaseAddr;
    logic [ADDRESS_WIDTH:0]   iLength;
    logic [DATA_WIDTH-1:0]    iSeed;
    logic [DATA_WIDTH-1:0]    iMemData;
    logic                     oChipSelect_n;
    logic                     oRead_n;
    logic                     oWrite_n;
    logic [ADDRESS_WIDTH-1:0] oAddress;
    logic [DATA_WIDTH-1:0]    oData;
    logic                     oBusy;
    logic                     oDone;
    logic [DATA_WIDTH-1:0]    oSum;
    logic [ADDRESS_WIDTH:0]   oErrCount;

    modport master (
        input  iStart, iOp, iBaseAddr, iLength, iSeed, iMemData,
        output oChipSelect_n, oRead_n, oWrite_n, oAddress, oData,
               oBusy, oDone, oSum, oErrCount
    );

    modport slave (
        output iStart, iOp, iBaseAddr, iLength, iSeed, iMemData,
        input  oChipSelect_n, oRead_n, oWrite_n, oAddress, oData,
               oBusy, oDone, oSum, oErrCount
    );
endinterface

// File: rtl/mem_burst_master.sv
// rtl/mem_burst_master.sv - burst fill/check initiator for the single-port synchronous memory
module mem_burst_master #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 4
) (
    input logic iClk,
    input logic iReset,
    mem_burst_master_if.master bus
);
    localparam logic [ADDRESS_WIDTH:0] MAX_LEN = {1'b1, {ADDRESS_WIDTH{1'b0}}};
    localparam logic [ADDRESS_WIDTH:0] LEN_ONE = 1;

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t                   state, nextState;
    logic [ADDRESS_WIDTH:0]   k, nextK, lenReg, nextLen, lenSat;
    logic [ADDRESS_WIDTH-1:0] baseReg, nextBase;
    logic [DATA_WIDTH-1:0]    seedReg, nextSeed;
    logic                     startAccept, lastWord;

    logic                     csD, rdD, wrD, busyD, doneD;
    logic [ADDRESS_WIDTH-1:0] addrD;
    logic [DATA_WIDTH-1:0]    dataD;

    logic                     csQ, rdQ, wrQ, busyQ, doneQ;
    logic [ADDRESS_WIDTH-1:0] addrQ;
    logic [DATA_WIDTH-1:0]    dataQ;

    logic                     pipeValid;
    logic [DATA_WIDTH-1:0]    pipeExp;
    logic [DATA_WIDTH-1:0]    sumQ;
    logic [ADDRESS_WIDTH:0]   errQ;

    assign lenSat      = (bus.iLength > MAX_LEN) ? MAX_LEN : bus.iLength;
    assign startAccept = (state == IDLE) && bus.iStart;
    assign lastWord    = (k == lenReg - LEN_ONE);

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state   <= IDLE;
            k       <= '0;
            lenReg  <= '0;
            baseReg <= '0;
            seedReg <= '0;
            csQ     <= 1'b1;
            rdQ     <= 1'b1;
            wrQ     <= 1'b1;
            addrQ   <= '0;
            dataQ   <= '0;
            busyQ   <= 1'b0;
            doneQ   <= 1'b0;
        end else begin
            state   <= nextState;
            k       <= nextK;
            lenReg  <= nextLen;
            baseReg <= nextBase;
            seedReg <= nextSeed;
            csQ     <= csD;
            rdQ     <= rdD;
            wrQ     <= wrD;
            addrQ   <= addrD;
            dataQ   <= dataD;
            busyQ   <= busyD;
            doneQ   <= doneD;
        end
    end

    always_comb begin
        nextState = state;
        nextK     = k;
        nextLen   = lenReg;
        nextBase  = baseReg;
        nextSeed  = seedReg;
        case (state)
            IDLE: begin
                if (bus.iStart) begin
                    nextLen  = lenSat;
                    nextBase = bus.iBaseAddr;
                    nextSeed = bus.iSeed;
                    nextK    = '0;
                    if (lenSat == '0)
                        nextState = DONE;
                    else
                        nextState = bus.iOp ? READ : WRITE;
                end
            end
            WRITE: begin
                if (lastWord) nextState = DONE;
                else          nextK = k + LEN_ONE;
            end
            READ: begin
                if (lastWord) nextState = DRAIN;
                else          nextK = k + LEN_ONE;
            end
            DRAIN:   nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state/index so the registered bus matches cycle k.
    always_comb begin
        csD   = 1'b1;
        rdD   = 1'b1;
        wrD   = 1'b1;
        addrD = '0;
        dataD = '0;
        busyD = (nextState != IDLE);
        doneD = (nextState == DONE);
        case (nextState)
            WRITE: begin
                csD   = 1'b0;
                wrD   = 1'b0;
                addrD = nextBase + nextK[ADDRESS_WIDTH-1:0];
                dataD = nextSeed + DATA_WIDTH'(nextK);
            end
            READ: begin
                csD   = 1'b0;
                rdD   = 1'b0;
                addrD = nextBase + nextK[ADDRESS_WIDTH-1:0];
            end
            default: ;
        endcase
    end

    // Read data arrives one cycle after the strobe; the pipeline carries the expected word along.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            pipeValid <= 1'b0;
            pipeExp   <= '0;
            sumQ      <= '0;
            errQ      <= '0;
        end else begin
            pipeValid <= (state == READ);
            pipeExp   <= seedReg + DATA_WIDTH'(k);
            if (startAccept && bus.iOp && (lenSat != '0)) begin
                sumQ <= '0;
                errQ <= '0;
            end else if (pipeValid) begin
                sumQ <= sumQ + bus.iMemData;
                if (bus.iMemData != pipeExp)
                    errQ <= errQ + LEN_ONE;
            end
        end
    end

    assign bus.oChipSelect_n = csQ;
    assign bus.oRead_n       = rdQ;
    assign bus.oWrite_n      = wrQ;
    assign bus.oAddress      = addrQ;
    assign bus.oData         = dataQ;
    assign bus.oBusy         = busyQ;
    assign bus.oDone         = doneQ;
    assign bus.oSum          = sumQ;
    assign bus.oErrCount     = errQ;
endmodule

// File: tb/tb_mem_burst_master.sv
// tb/tb_mem_burst_master.sv - scoreboard bench for mem_burst_master against a registered-read memory model
module tb_mem_burst_master;
    localparam int DW = 32;
    localparam int AW = 4;

    logic iClk = 1'b0;
    logic iReset = 1'b1;
    always #5 iClk = ~iClk;

    mem_burst_master_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    mem_burst_master #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .iClk  (iClk),
        .iReset(iReset),
        .bus   (bus.master)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] memQ;
    always @(posedge iClk) begin
        if (iReset) begin
            memQ <= '0;
        end else begin
            if (!bus.oChipSelect_n && !bus.oWrite_n) mem[bus.oAddress] <= bus.oData;
            if (!bus.oChipSelect_n && !bus.oRead_n) memQ <= mem[bus.oAddress];
        end
    end
    assign bus.iMemData = memQ;

    typedef struct {
        logic          isWrite;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } busTxn_t;

    busTxn_t       sbQ[$];
    logic [DW-1:0] refMem [0:(1<<AW)-1];
    int            nChecks = 0;
    int            nFails  = 0;

    task automatic pushBurst(input logic op, input logic [AW-1:0] base, input int len,
                             input logic [DW-1:0] seed, output logic [DW-1:0] expSum,
                             output int expErr);
        logic [AW-1:0] a;
        logic [DW-1:0] p;
        expSum = '0;
        expErr = 0;
        for (int i = 0; i < len; i++) begin
            a = base + AW'(i);
            p = seed + DW'(i);
            if (!op) begin
                sbQ.push_back('{1'b1, a, p});
                refMem[a] = p;
            end else begin
                sbQ.push_back('{1'b0, a, '0});
                expSum = expSum + refMem[a];
                if (refMem[a] !== p) expErr++;
            end
        end
    endtask

    task automatic checkBusCycle(input string name, input int cyc, input logic busCyc);
        busTxn_t t;
        nChecks++;
        if (bus.oChipSelect_n !== !busCyc) begin
            nFails++;
            $display("FAIL %s cs_n cycle %0d: got %b want %b", name, cyc, bus.oChipSelect_n, !busCyc);
        end
        nChecks++;
        if (!bus.oRead_n && !bus.oWrite_n) begin
            nFails++;
            $display("FAIL %s strobe clash cycle %0d: got rd_n=0 wr_n=0 want not both 0", name, cyc);
        end
        if (busCyc) begin
            nChecks++;
            if (sbQ.size() == 0) begin
                nFails++;
                $display("FAIL %s scoreboard cycle %0d: got access want none queued", name, cyc);
            end else begin
                t = sbQ.pop_front();
                if (bus.oWrite_n !== !t.isWrite || bus.oRead_n !== t.isWrite ||
                    bus.oAddress !== t.addr || bus.oData !== t.data) begin
                    nFails++;
                    $display("FAIL %s access cycle %0d: got wr_n=%b rd_n=%b a=%0d d=%h want wr_n=%b rd_n=%b a=%0d d=%h",
                             name, cyc, bus.oWrite_n, bus.oRead_n, bus.oAddress, bus.oData,
                             !t.isWrite, t.isWrite, t.addr, t.data);
                end
            end
        end
    endtask

    task automatic checkStatus(input string name, input int cyc, input logic busyExp, input logic doneExp);
        nChecks++;
        if (bus.oBusy !== busyExp || bus.oDone !== doneExp) begin
            nFails++;
            $display("FAIL %s busy/done cycle %0d: got %b/%b want %b/%b", name, cyc, bus.oBusy, bus.oDone, busyExp, doneExp);
        end
    endtask

    task automatic runBurst(input string name, input logic op, input logic [AW-1:0] base,
                            input int len, input logic [DW-1:0] seed);
        logic [DW-1:0] expSum;
        int            expErr;
        int            doneCyc;
        pushBurst(op, base, len, seed, expSum, expErr);
        doneCyc = (len == 0) ? 1 : (op ? len + 2 : len + 1);
        @(negedge iClk);
        bus.iOp       = op;
        bus.iBaseAddr = base;
        bus.iLength   = (AW+1)'(len);
        bus.iSeed     = seed;
        bus.iStart    = 1'b1;
        @(posedge iClk);
        #1 bus.iStart = 1'b0;
        for (int cyc = 1; cyc <= doneCyc + 1; cyc++) begin
            @(negedge iClk);
            checkBusCycle(name, cyc, (cyc <= len));
            checkStatus(name, cyc, (cyc <= doneCyc), (cyc == doneCyc));
            if (op && cyc >= doneCyc) begin
                nChecks++;
                if (bus.oSum !== expSum || bus.oErrCount !== (AW+1)'(expErr)) begin
                    nFails++;
                    $display("FAIL %s sum/err cycle %0d: got %h/%0d want %h/%0d",
                             name, cyc, bus.oSum, bus.oErrCount, expSum, expErr);
                end
            end
        end
        nChecks++;
        if (sbQ.size() != 0) begin
            nFails++;
            $display("FAIL %s leftover: got %0d queued want 0", name, sbQ.size());
            sbQ.delete();
        end
    endtask

    task automatic test_reset();
        @(negedge iClk);
        nChecks++;
        if (bus.oChipSelect_n !== 1'b1 || bus.oRead_n !== 1'b1 || bus.oWrite_n !== 1'b1 ||
            bus.oAddress !== '0 || bus.oData !== '0 || bus.oBusy !== 1'b0 || bus.oDone !== 1'b0 ||
            bus.oSum !== '0 || bus.oErrCount !== '0) begin
            nFails++;
            $display("FAIL reset_values: got cs=%b rd=%b wr=%b a=%0d d=%h busy=%b done=%b sum=%h err=%0d want 1 1 1 0 0 0 0 0 0",
                     bus.oChipSelect_n, bus.oRead_n, bus.oWrite_n, bus.oAddress, bus.oData,
                     bus.oBusy, bus.oDone, bus.oSum, bus.oErrCount);
        end
        iReset = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        @(negedge iClk);
        bus.iOp = 1'b0; bus.iBaseAddr = 4'd8; bus.iLength = 5'd8; bus.iSeed = 32'hAA; bus.iStart = 1'b1;
        @(posedge iClk);
        #1 bus.iStart = 1'b0;
        @(negedge iClk);
        @(negedge iClk);
        nChecks++;
        if (bus.oChipSelect_n !== 1'b0 || bus.oWrite_n !== 1'b0 || bus.oAddress !== 4'd9) begin
            nFails++;
            $display("FAIL midreset_pre: got cs=%b wr=%b a=%0d want 0 0 9", bus.oChipSelect_n, bus.oWrite_n, bus.oAddress);
        end
        refMem[8] = 32'hAA;
        iReset = 1'b1;
        #1;
        nChecks++;
        if (bus.oChipSelect_n !== 1'b1 || bus.oRead_n !== 1'b1 || bus.oWrite_n !== 1'b1 ||
            bus.oBusy !== 1'b0 || bus.oAddress !== '0) begin
            nFails++;
            $display("FAIL midreset_async: got cs=%b rd=%b wr=%b busy=%b a=%0d want 1 1 1 0 0",
                     bus.oChipSelect_n, bus.oRead_n, bus.oWrite_n, bus.oBusy, bus.oAddress);
        end
        @(negedge iClk);
        iReset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge iClk);
            nChecks++;
            if (bus.oChipSelect_n !== 1'b1 || bus.oBusy !== 1'b0) begin
                nFails++;
                $display("FAIL midreset_idle %0d: got cs=%b busy=%b want 1 0", i, bus.oChipSelect_n, bus.oBusy);
            end
        end
    endtask

    task automatic test_start_held();
        logic [DW-1:0] s;
        int            e;
        pushBurst(1'b0, 4'd0, 2, 32'h55, s, e);
        pushBurst(1'b0, 4'd0, 2, 32'h55, s, e);
        @(negedge iClk);
        bus.iOp = 1'b0; bus.iBaseAddr = 4'd0; bus.iLength = 5'd2; bus.iSeed = 32'h55; bus.iStart = 1'b1;
        @(posedge iClk);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge iClk);
            if (cyc == 5) bus.iStart = 1'b0;
            checkBusCycle("start_held", cyc, (cyc == 1 || cyc == 2 || cyc == 5 || cyc == 6));
            checkStatus("start_held", cyc, (cyc != 4 && cyc != 8), (cyc == 3 || cyc == 7));
        end
        nChecks++;
        if (sbQ.size() != 0) begin
            nFails++;
            $display("FAIL start_held leftover: got %0d queued want 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) refMem[i] = '0;
        bus.iStart = 1'b0; bus.iOp = 1'b0; bus.iBaseAddr = '0; bus.iLength = '0; bus.iSeed = '0;
        test_reset();
        test_reset_mid_burst();
        runBurst("fill", 1'b0, 4'd3, 4, 32'h10);
        runBurst("check", 1'b1, 4'd3, 4, 32'h10);
        nChecks++;
        if (bus.oSum !== 32'h46 || bus.oErrCount !== 5'd0) begin
            nFails++;
            $display("FAIL check_const: got %h/%0d want 00000046/0", bus.oSum, bus.oErrCount);
        end
        runBurst("mismatch", 1'b1, 4'd3, 4, 32'h11);
        nChecks++;
        if (bus.oSum !== 32'h46 || bus.oErrCount !== 5'd4) begin
            nFails++;
            $display("FAIL mismatch_const: got %h/%0d want 00000046/4", bus.oSum, bus.oErrCount);
        end
        runBurst("wrap_fill", 1'b0, 4'd14, 4, 32'hFFFFFFFE);
        runBurst("wrap_check", 1'b1, 4'd14, 4, 32'hFFFFFFFE);
        nChecks++;
        if (bus.oSum !== 32'hFFFFFFFE || bus.oErrCount !== 5'd0) begin
            nFails++;
            $display("FAIL wrap_const: got %h/%0d want fffffffe/0", bus.oSum, bus.oErrCount);
        end
        runBurst("len0", 1'b0, 4'd5, 0, 32'h0);
        test_start_held();
        runBurst("full_check", 1'b1, 4'd0, 16, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
